// File: rtl/plab4_net_router_output_ctrl_arbiter_notp_if.sv
// rtl/plab4_net_router_output_ctrl_arbiter_notp_if.sv - request/grant bundle between input controls and one output arbiter
//
// Purpose: groups the per-domain request vectors, the downstream ready and
//          every arbiter result into one bundle.
// Signals:
//   reqs_d0, reqs_d1 : 3-bit request vectors, bit i = input i wants this output
//   out_rdy          : downstream can take a flit this cycle
//   grants_d0/_d1    : one-hot grant per domain, or 0
//   grants           : OR of both domain grants
//   sel              : crossbar select, 0..2 = winning input, 3 = idle
//   cur_domain       : domain of the current winner (0 when idle)
//   out_val          : a flit is forwarded this cycle
// Modports: master = requester/downstream side, slave = arbiter side.

interface plab4_net_router_output_ctrl_arbiter_notp_if;
    logic [2:0] reqs_d0;
    logic [2:0] reqs_d1;
    logic       out_rdy;
    logic [2:0] grants_d0;
    logic [2:0] grants_d1;
    logic [2:0] grants;
    logic [1:0] sel;
    logic       cur_domain;
    logic       out_val;

    modport master (
        output reqs_d0, reqs_d1, out_rdy,
        input  grants_d0, grants_d1, grants, sel, cur_domain, out_val
    );

    modport slave (
        input  reqs_d0, reqs_d1, out_rdy,
        output grants_d0, grants_d1, grants, sel, cur_domain, out_val
    );
endinterface

// File: rtl/plab4_net_router_output_ctrl_arbiter_notp.sv
// rtl/plab4_net_router_output_ctrl_arbiter_notp.sv - two-domain output-port arbiter with D0 priority and D1 anti-starvation
//
// Purpose: picks one domain and one input per cycle for a router output port.
//          D0 has strict priority unless D1 has been waiting through
//          p_max_streak consecutive D0 transfers; within a domain the winner
//          is chosen round-robin. The grant path is purely combinational.
// Ports:
//   clk   : clock, all state updates on posedge
//   reset : synchronous, active-high
//   arb   : slave side of the request/grant bundle (see the _if file)

module plab4_net_router_output_ctrl_arbiter_notp #(
    parameter int p_num_reqs   = 3,
    parameter int p_max_streak = 4
) (
    input  logic clk,
    input  logic reset,
    plab4_net_router_output_ctrl_arbiter_notp_if.slave arb
);

    // A limit of 0 disables the streak logic; keep the counter at least 1 bit wide.
    localparam int c_streak_nbits = (p_max_streak > 0) ? $clog2(p_max_streak + 1) : 1;
    localparam logic [c_streak_nbits-1:0] c_max_streak = c_streak_nbits'(p_max_streak);
    localparam logic [p_num_reqs-1:0]     c_ptr_reset  = p_num_reqs'(1);

    logic [p_num_reqs-1:0]     rr_d0_q, rr_d0_d;
    logic [p_num_reqs-1:0]     rr_d1_q, rr_d1_d;
    logic [c_streak_nbits-1:0] streak_q, streak_d;

    logic                  any_d0, any_d1;
    logic                  force_d1;
    logic                  pick_d0, pick_d1;
    logic                  qual;
    logic [p_num_reqs-1:0] win_d0, win_d1;
    logic [p_num_reqs-1:0] grants_d0, grants_d1, grants;

    // First requesting bit at or after the one-hot pointer, wrapping 2 -> 0.
    function automatic logic [p_num_reqs-1:0] rr_pick(
        input logic [p_num_reqs-1:0] reqs,
        input logic [p_num_reqs-1:0] ptr
    );
        logic [p_num_reqs-1:0] win;
        win = '0;
        case (ptr)
            3'b010:  win = reqs[1] ? 3'b010 : reqs[2] ? 3'b100 : reqs[0] ? 3'b001 : 3'b000;
            3'b100:  win = reqs[2] ? 3'b100 : reqs[0] ? 3'b001 : reqs[1] ? 3'b010 : 3'b000;
            default: win = reqs[0] ? 3'b001 : reqs[1] ? 3'b010 : reqs[2] ? 3'b100 : 3'b000;
        endcase
        return win;
    endfunction

    always_comb begin
        any_d0   = |arb.reqs_d0;
        any_d1   = |arb.reqs_d1;
        // D1 is forced only once the streak has hit the limit and D1 still waits.
        force_d1 = (p_max_streak != 0) && (streak_q == c_max_streak) && any_d1;
        pick_d0  = any_d0 && !force_d1;
        pick_d1  = any_d1 && !pick_d0;

        win_d0 = rr_pick(arb.reqs_d0, rr_d0_q);
        win_d1 = rr_pick(arb.reqs_d1, rr_d1_q);

        // Grants are suppressed while stalled or in reset, but the domain
        // choice is still reported through cur_domain.
        qual      = arb.out_rdy && !reset;
        grants_d0 = (pick_d0 && qual) ? win_d0 : '0;
        grants_d1 = (pick_d1 && qual) ? win_d1 : '0;
        grants    = grants_d0 | grants_d1;
    end

    always_comb begin
        arb.grants_d0  = grants_d0;
        arb.grants_d1  = grants_d1;
        arb.grants     = grants;
        arb.out_val    = |grants;
        arb.cur_domain = pick_d1;
        case (grants)
            3'b001:  arb.sel = 2'd0;
            3'b010:  arb.sel = 2'd1;
            3'b100:  arb.sel = 2'd2;
            default: arb.sel = 2'd3;
        endcase
    end

    always_comb begin
        rr_d0_d  = rr_d0_q;
        rr_d1_d  = rr_d1_q;
        streak_d = streak_q;

        // The winner's neighbour becomes the highest priority next time.
        if (|grants_d0) begin
            rr_d0_d = {grants_d0[p_num_reqs-2:0], grants_d0[p_num_reqs-1]};
        end
        if (|grants_d1) begin
            rr_d1_d = {grants_d1[p_num_reqs-2:0], grants_d1[p_num_reqs-1]};
        end

        // The streak only measures D0 transfers that happen while D1 waits.
        if ((|grants_d1) || !any_d1) begin
            streak_d = '0;
        end else if ((|grants_d0) && (streak_q != c_max_streak)) begin
            streak_d = streak_q + c_streak_nbits'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_d0_q  <= c_ptr_reset;
            rr_d1_q  <= c_ptr_reset;
            streak_q <= '0;
        end else begin
            rr_d0_q  <= rr_d0_d;
            rr_d1_q  <= rr_d1_d;
            streak_q <= streak_d;
        end
    end

endmodule

// File: tb/tb_plab4_net_router_output_ctrl_arbiter_notp.sv
// tb/tb_plab4_net_router_output_ctrl_arbiter_notp.sv - scoreboard bench for the two-domain output arbiter

module tb_plab4_net_router_output_ctrl_arbiter_notp;

    localparam int MAX = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    plab4_net_router_output_ctrl_arbiter_notp_if bus ();

    plab4_net_router_output_ctrl_arbiter_notp #(
        .p_num_reqs   (3),
        .p_max_streak (MAX)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .arb   (bus)
    );

    typedef struct packed {
        logic [2:0] g0;
        logic [2:0] g1;
        logic [1:0] sel;
        logic       cd;
        logic       ov;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;
    bit    rand_phase = 1'b0;
    int    d1_wait = 0;

    exp_t  mon_e;
    exp_t  mon_got;
    string mon_nm;

    int m_p0, m_p1, m_streak;

    // Drive one cycle of inputs just after the edge and queue its expected outputs.
    task automatic drive(input logic r, input logic [2:0] d0, input logic [2:0] d1,
                         input logic rdy, input logic [2:0] eg0, input logic [2:0] eg1,
                         input logic [1:0] es, input logic ecd, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        reset       = r;
        bus.reqs_d0 = d0;
        bus.reqs_d1 = d1;
        bus.out_rdy = rdy;
        e.g0  = eg0;
        e.g1  = eg1;
        e.sel = es;
        e.cd  = ecd;
        e.ov  = |(eg0 | eg1);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Reference model with integer pointers; updates its own state per cycle.
    task automatic model_step(input logic [2:0] d0, input logic [2:0] d1, input logic rdy,
                              output logic [2:0] eg0, output logic [2:0] eg1,
                              output logic [1:0] es, output logic ecd);
        bit         frc;
        bit         xfer;
        int         dom;
        int         w;
        int         p;
        logic [2:0] rq;
        frc = (MAX != 0) && (m_streak == MAX) && (d1 != 3'b000);
        dom = -1;
        if (d0 != 3'b000 && !frc)  dom = 0;
        else if (d1 != 3'b000)     dom = 1;
        rq = (dom == 0) ? d0 : d1;
        p  = (dom == 0) ? m_p0 : m_p1;
        w  = -1;
        if (dom >= 0) begin
            for (int k = 0; k < 3; k++) begin
                int i;
                i = (p + k) % 3;
                if (w < 0 && rq[i]) w = i;
            end
        end
        xfer = rdy && (dom >= 0);
        eg0  = (xfer && dom == 0) ? 3'(1 << w) : 3'b000;
        eg1  = (xfer && dom == 1) ? 3'(1 << w) : 3'b000;
        es   = xfer ? 2'(w) : 2'd3;
        ecd  = (dom == 1);
        if (xfer && dom == 0) m_p0 = (w + 1) % 3;
        if (xfer && dom == 1) m_p1 = (w + 1) % 3;
        if ((xfer && dom == 1) || d1 == 3'b000) m_streak = 0;
        else if (xfer && dom == 0 && m_streak < MAX) m_streak = m_streak + 1;
    endtask

    // Monitor: outputs are combinational, so one expectation per cycle is popped mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e  = exp_q.pop_front();
            mon_nm = name_q.pop_front();
            mon_got.g0  = bus.grants_d0;
            mon_got.g1  = bus.grants_d1;
            mon_got.sel = bus.sel;
            mon_got.cd  = bus.cur_domain;
            mon_got.ov  = bus.out_val;
            checks++;
            if (mon_got !== mon_e || bus.grants !== (mon_e.g0 | mon_e.g1)) begin
                errors++;
                $display("FAIL %s: got g0=%b g1=%b grants=%b sel=%0d cd=%b ov=%b, want g0=%b g1=%b grants=%b sel=%0d cd=%b ov=%b",
                         mon_nm, bus.grants_d0, bus.grants_d1, bus.grants, bus.sel, bus.cur_domain, bus.out_val,
                         mon_e.g0, mon_e.g1, mon_e.g0 | mon_e.g1, mon_e.sel, mon_e.cd, mon_e.ov);
            end
        end
        if (rand_phase) begin
            checks++;
            if (!$onehot0(bus.grants)) begin
                errors++;
                $display("FAIL onehot: grants=%b", bus.grants);
            end
            checks++;
            if ((bus.grants_d0 & bus.grants_d1) != 3'b000) begin
                errors++;
                $display("FAIL disjoint: g0=%b g1=%b", bus.grants_d0, bus.grants_d1);
            end
            checks++;
            if (((bus.grants_d0 & ~bus.reqs_d0) | (bus.grants_d1 & ~bus.reqs_d1)) != 3'b000) begin
                errors++;
                $display("FAIL subset: g0=%b reqs_d0=%b g1=%b reqs_d1=%b",
                         bus.grants_d0, bus.reqs_d0, bus.grants_d1, bus.reqs_d1);
            end
            if (reset || bus.reqs_d1 == 3'b000 || bus.grants_d1 != 3'b000) d1_wait = 0;
            else if (bus.grants_d0 != 3'b000) d1_wait++;
            checks++;
            if (d1_wait > MAX + 1) begin
                errors++;
                $display("FAIL starvation: d1 waited %0d transfers, limit %0d", d1_wait, MAX + 1);
            end
        end
    end

    initial begin
        logic [2:0] rd0, rd1, eg0, eg1;
        logic [1:0] es;
        logic       ecd, rrdy;
        int         n;

        reset       = 1'b1;
        bus.reqs_d0 = 3'b000;
        bus.reqs_d1 = 3'b000;
        bus.out_rdy = 1'b0;

        // Reset held with requests present, then D0 round-robin.
        drive(1, 3'b111, 3'b000, 1, 3'b000, 3'b000, 2'd3, 0, "t1_reset_a");
        drive(1, 3'b111, 3'b000, 1, 3'b000, 3'b000, 2'd3, 0, "t1_reset_b");
        drive(0, 3'b111, 3'b000, 1, 3'b001, 3'b000, 2'd0, 0, "t2_rr0");
        drive(0, 3'b111, 3'b000, 1, 3'b010, 3'b000, 2'd1, 0, "t2_rr1");
        drive(0, 3'b111, 3'b000, 1, 3'b100, 3'b000, 2'd2, 0, "t2_rr2");
        drive(0, 3'b111, 3'b000, 1, 3'b001, 3'b000, 2'd0, 0, "t2_rr3");

        // Streak limit forces D1 after four D0 transfers.
        drive(1, 3'b000, 3'b000, 1, 3'b000, 3'b000, 2'd3, 0, "t3_reset");
        repeat (4) drive(0, 3'b001, 3'b010, 1, 3'b001, 3'b000, 2'd0, 0, "t3_d0");
        drive(0, 3'b001, 3'b010, 1, 3'b000, 3'b010, 2'd1, 1, "t3_force_d1");
        repeat (4) drive(0, 3'b001, 3'b010, 1, 3'b001, 3'b000, 2'd0, 0, "t3_resume");
        drive(0, 3'b001, 3'b010, 1, 3'b000, 3'b010, 2'd1, 1, "t3_force_again");
        // D1 dropping its request clears the streak.
        repeat (3) drive(0, 3'b001, 3'b010, 1, 3'b001, 3'b000, 2'd0, 0, "t3_pre_drop");
        drive(0, 3'b001, 3'b000, 1, 3'b001, 3'b000, 2'd0, 0, "t3_drop");
        repeat (4) drive(0, 3'b001, 3'b010, 1, 3'b001, 3'b000, 2'd0, 0, "t3_after_drop");
        drive(0, 3'b001, 3'b010, 1, 3'b000, 3'b010, 2'd1, 1, "t3_force_after_drop");

        // Stall holds state; cur_domain still reports the choice.
        drive(1, 3'b000, 3'b000, 1, 3'b000, 3'b000, 2'd3, 0, "t4_reset");
        repeat (3) drive(0, 3'b100, 3'b000, 0, 3'b000, 3'b000, 2'd3, 0, "t4_stall");
        drive(0, 3'b100, 3'b000, 1, 3'b100, 3'b000, 2'd2, 0, "t4_go");
        drive(0, 3'b111, 3'b000, 1, 3'b001, 3'b000, 2'd0, 0, "t4_ptr_wrap");
        drive(0, 3'b000, 3'b010, 0, 3'b000, 3'b000, 2'd3, 1, "t4_stall_d1");
        drive(0, 3'b000, 3'b010, 1, 3'b000, 3'b010, 2'd1, 1, "t4_go_d1");

        // D1 alone round-robins; shared input goes to D0 only.
        drive(1, 3'b000, 3'b000, 1, 3'b000, 3'b000, 2'd3, 0, "t5_reset");
        drive(0, 3'b000, 3'b101, 1, 3'b000, 3'b001, 2'd0, 1, "t5_a");
        drive(0, 3'b000, 3'b101, 1, 3'b000, 3'b100, 2'd2, 1, "t5_b");
        drive(0, 3'b000, 3'b101, 1, 3'b000, 3'b001, 2'd0, 1, "t5_c");
        drive(0, 3'b010, 3'b010, 1, 3'b010, 3'b000, 2'd1, 0, "same_input");
        drive(1, 3'b111, 3'b000, 1, 3'b000, 3'b000, 2'd3, 0, "reset_midop");
        drive(0, 3'b111, 3'b000, 1, 3'b001, 3'b000, 2'd0, 0, "after_reset");

        // Random traffic against the reference model plus invariants.
        drive(1, 3'b000, 3'b000, 1, 3'b000, 3'b000, 2'd3, 0, "rand_reset");
        m_p0 = 0;
        m_p1 = 0;
        m_streak = 0;
        rand_phase = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            rd0  = 3'($urandom_range(0, 7));
            rd1  = 3'($urandom_range(0, 7));
            rrdy = ($urandom_range(0, 3) != 0);
            model_step(rd0, rd1, rrdy, eg0, eg1, es, ecd);
            drive(0, rd0, rd1, rrdy, eg0, eg1, es, ecd, "random");
        end

        n = 0;
        while (exp_q.size() > 0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        rand_phase = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
